// File: rtl/data_memory_seq.sv
// Byte-addressed little-endian data memory with registered one-cycle response,
// sequential post-reset clear engine and a registered debug word.
module data_memory_seq #(
    parameter int         DATA_W      = 16,
    parameter int         ADDR_W      = 16,
    parameter int         DEPTH_BYTES = 1024,
    parameter logic [7:0] INIT0       = 8'h99,
    parameter logic [7:0] INIT1       = 8'hAB,
    parameter int         TEST_ADDR   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [DATA_W-1:0] test_word
);

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH_BYTES - BPW);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  clr_ptr;
    logic [7:0]        mem [DEPTH_BYTES];

    logic              accept;
    logic              addr_err;
    logic [ADDR_W:0]   nbytes;
    logic [ADDR_W:0]   req_end;
    logic [IDX_W-1:0]  base;
    logic [DATA_W-1:0] rd_word;

    function automatic logic [7:0] clear_byte(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(0))
            return INIT0;
        else if (idx == IDX_W'(1))
            return INIT1;
        else
            return 8'h00;
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state == CLEAR);
    assign accept    = req_valid & req_ready;

    // Range check is done one bit wider than the address so a request near
    // the top of the address space cannot wrap around and look legal.
    assign nbytes   = req_size ? (ADDR_W+1)'(BPW) : (ADDR_W+1)'(1);
    assign req_end  = {1'b0, req_addr} + nbytes;
    assign addr_err = (req_end > (ADDR_W+1)'(DEPTH_BYTES));
    assign base     = req_addr[IDX_W-1:0];

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_ptr == LAST_PTR)
            state_next = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_ptr <= clr_ptr + IDX_W'(BPW);
        end
    end

    // Array has no reset; the clear engine owns it until IDLE.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            for (int k = 0; k < BPW; k++)
                mem[clr_ptr + IDX_W'(k)] <= clear_byte(clr_ptr + IDX_W'(k));
        end else if (accept && req_write && !addr_err) begin
            for (int k = 0; k < BPW; k++)
                if (k == 0 || req_size)
                    mem[base + IDX_W'(k)] <= req_wdata[8*k +: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < BPW; k++)
            if (k == 0 || req_size)
                rd_word[8*k +: 8] = mem[base + IDX_W'(k)];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & addr_err;
            rsp_rdata <= (accept && !req_write && !addr_err) ? rd_word : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            test_word <= '0;
        end else begin
            for (int k = 0; k < BPW; k++)
                test_word[8*k +: 8] <= mem[IDX_W'(TEST_ADDR + k)];
        end
    end

endmodule
